proc_exec_core: RTL and testbench
=================================

Name: proc_exec_core

Overview:
- Execution core of the distributed pulse processor: control FSM, registered 3-op-bit ALU and instruction pointer in one block.
- Decodes the 8-bit opcode of the current command word and sequences the ALU.
- Produces register/qclk write strobes, pulse strobe (cstrobe) and sync/fproc handshakes.
- Drives the command-memory read address; command memory, register file and qclk live outside.

Parameters:
DATA_WIDTH, 32, ALU/data/qclk width
CMD_ADDR_WIDTH, 8, instruction pointer width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
opcode  in  8  opcode of command at instr_ptr (valid one cycle after instr_ptr changes)
imm_data  in  DATA_WIDTH  immediate operand from command word
reg_data0  in  DATA_WIDTH  register-file read port 0
reg_data1  in  DATA_WIDTH  register-file read port 1
qclk_val  in  DATA_WIDTH  current qclk value
pulse_time  in  DATA_WIDTH  pulse trigger time from command word
jump_addr  in  CMD_ADDR_WIDTH  jump target from command word
sync_enable  in  1  sync barrier released
fproc_enable  in  1  fproc result ready
instr_ptr  out  CMD_ADDR_WIDTH  command-memory read address
alu_out  out  DATA_WIDTH  registered ALU result (reg-file / qclk write data)
reg_write_en  out  1  register-file write strobe
qclk_load_en  out  1  qclk load strobe (load value = alu_out)
cstrobe  out  1  pulse command strobe
sync_out_ready  out  1  waiting at sync barrier
fproc_out_ready  out  1  waiting on fproc
done  out  1  program halted

Behaviour:
- Opcode fields: [7:4] instruction class, [3] in0 select (1=reg_data0, 0=imm_data), [2:0] ALU op.
- in1 is qclk_val for class INC_QCLK, otherwise reg_data1.
- ALU ops; result registered every clk, one cycle latency:
  - 000 in0; 001 in0+in1 (mod 2^DATA_WIDTH); 010 in0-in1 (mod 2^DATA_WIDTH).
  - 011 eq: 1 if in0==in1, else 0.
  - 100 le: 1 if in0<=in1, signed.
  - 101 ge: 1 if in0>=in1, signed.
  - 110 zero: 0.
  - 111 in1.
- Classes: 0x0 REG_ALU, 0x1 JUMP_I, 0x2 JUMP_COND, 0x4 INC_QCLK, 0x5 PULSE, 0x7 SYNC, 0x8 FPROC, 0x9 DONE; all other values are NOP.
- instr_ptr register updates only on an advance:
  - load=1 -> jump_addr; load=0 -> ptr+1, wrapping 2^CMD_ADDR_WIDTH-1 -> 0.
  - Load takes priority over increment.
- FSM states FETCH, DECODE, ALU_WB, HALT; every pointer advance goes to FETCH.
- FETCH: one idle cycle for memory read latency, then DECODE.
- DECODE:
  - REG_ALU, JUMP_COND, INC_QCLK: ALU captures the result this cycle -> ALU_WB.
  - JUMP_I: advance with load.
  - PULSE: internal strobe-enable=1; cstrobe = (qclk_val==pulse_time) & enable, combinational. Advance in the cstrobe cycle; otherwise stay in DECODE.
  - SYNC: sync_out_ready=1; advance in the cycle sync_enable=1, else stay.
  - FPROC: fproc_out_ready=1; advance in the cycle fproc_enable=1, else stay.
  - DONE: -> HALT without advancing.
  - NOP: advance.
- ALU_WB: opcode is still stable; then advance.
  - REG_ALU: reg_write_en=1.
  - INC_QCLK: qclk_load_en=1.
  - JUMP_COND: load = alu_out[0].
- HALT: done=1; pointer frozen; stays until reset.
- Strobes are single-cycle pulses; cstrobe, sync_out_ready and fproc_out_ready are 0 outside DECODE.
- Throughput: NOP/JUMP_I 2 cycles; ALU classes 3 cycles; wait classes 2 + wait cycles.
- Reset (reset==0 at clk edge): takes effect on any state, including mid-wait or in HALT.
  - instr_ptr=0, state=FETCH, alu_out=0.
  - reg_write_en, qclk_load_en, cstrobe, sync_out_ready, fproc_out_ready, done = 0.

Test Plan:
- Reset released, opcodes all NOP -> instr_ptr 0,1,2,... stepping every 2 cycles; wraps 255 -> 0.
- REG_ALU ADD, in0 sel=1, reg_data0=5, reg_data1=7 -> alu_out=12 with reg_write_en=1 exactly one cycle, in ALU_WB.
- JUMP_COND EQ with operands 3,3 -> instr_ptr=jump_addr. With 3,4 -> instr_ptr+1. SUB 0-1 -> alu_out=0xFFFFFFFF.
- PULSE, pulse_time=10, qclk_val counting from 0 -> cstrobe high only when qclk_val==10, pointer advances that cycle. INC_QCLK imm 4 + qclk_val 20 -> alu_out=24, qclk_load_en=1.
- SYNC held with sync_enable=0 for 5 cycles -> sync_out_ready high, pointer frozen; sync_enable=1 -> advance. Same for FPROC/fproc_enable.
- DONE -> done=1, pointer frozen. Reset asserted mid-SYNC wait and in HALT -> all outputs 0, instr_ptr=0 next edge.

Source files
------------

// File: rtl/proc_exec_core.sv
// Execution core of the pulse processor: control FSM, registered ALU and
// instruction pointer. Command memory, register file and qclk live outside.
module proc_exec_core #(
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                opcode,
  input  logic [DATA_WIDTH-1:0]     imm_data,
  input  logic [DATA_WIDTH-1:0]     reg_data0,
  input  logic [DATA_WIDTH-1:0]     reg_data1,
  input  logic [DATA_WIDTH-1:0]     qclk_val,
  input  logic [DATA_WIDTH-1:0]     pulse_time,
  input  logic [CMD_ADDR_WIDTH-1:0] jump_addr,
  input  logic                      sync_enable,
  input  logic                      fproc_enable,
  output logic [CMD_ADDR_WIDTH-1:0] instr_ptr,
  output logic [DATA_WIDTH-1:0]     alu_out,
  output logic                      reg_write_en,
  output logic                      qclk_load_en,
  output logic                      cstrobe,
  output logic                      sync_out_ready,
  output logic                      fproc_out_ready,
  output logic                      done
);

  // state   | meaning
  // FETCH   | idle cycle covering command-memory read latency
  // DECODE  | act on instruction class, wait for pulse/sync/fproc
  // ALU_WB  | registered ALU result available, write back / branch
  // HALT    | program finished, pointer frozen until reset
  typedef enum logic [1:0] {FETCH, DECODE, ALU_WB, HALT} state_t;

  localparam logic [3:0] CLS_REG_ALU   = 4'h0;
  localparam logic [3:0] CLS_JUMP_I    = 4'h1;
  localparam logic [3:0] CLS_JUMP_COND = 4'h2;
  localparam logic [3:0] CLS_INC_QCLK  = 4'h4;
  localparam logic [3:0] CLS_PULSE     = 4'h5;
  localparam logic [3:0] CLS_SYNC      = 4'h7;
  localparam logic [3:0] CLS_FPROC     = 4'h8;
  localparam logic [3:0] CLS_DONE      = 4'h9;

  state_t state, state_nxt;

  logic [3:0]            cls;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] in0, in1, alu_nxt;
  logic                  cmp_eq, cmp_le, cmp_ge;
  logic                  advance, load, strobe_en;

  assign cls    = opcode[7:4];
  assign alu_op = opcode[2:0];
  assign in0    = opcode[3] ? reg_data0 : imm_data;
  assign in1    = (cls == CLS_INC_QCLK) ? qclk_val : reg_data1;
  assign cmp_eq = (in0 == in1);
  assign cmp_le = ($signed(in0) <= $signed(in1));
  assign cmp_ge = ($signed(in0) >= $signed(in1));

  always_comb begin
    alu_nxt = '0;
    case (alu_op)
      3'b000: alu_nxt = in0;
      3'b001: alu_nxt = in0 + in1;
      3'b010: alu_nxt = in0 - in1;
      3'b011: alu_nxt = {{(DATA_WIDTH-1){1'b0}}, cmp_eq};
      3'b100: alu_nxt = {{(DATA_WIDTH-1){1'b0}}, cmp_le};
      3'b101: alu_nxt = {{(DATA_WIDTH-1){1'b0}}, cmp_ge};
      3'b110: alu_nxt = '0;
      default: alu_nxt = in1;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    advance         = 1'b0;
    load            = 1'b0;
    strobe_en       = 1'b0;
    reg_write_en    = 1'b0;
    qclk_load_en    = 1'b0;
    sync_out_ready  = 1'b0;
    fproc_out_ready = 1'b0;
    done            = 1'b0;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (cls)
          CLS_REG_ALU, CLS_JUMP_COND, CLS_INC_QCLK: state_nxt = ALU_WB;
          CLS_JUMP_I: begin
            advance = 1'b1;
            load    = 1'b1;
          end
          CLS_PULSE: begin
            strobe_en = 1'b1;
            advance   = (qclk_val == pulse_time);
          end
          CLS_SYNC: begin
            sync_out_ready = 1'b1;
            advance        = sync_enable;
          end
          CLS_FPROC: begin
            fproc_out_ready = 1'b1;
            advance         = fproc_enable;
          end
          CLS_DONE: state_nxt = HALT;
          default: advance = 1'b1;
        endcase
      end
      ALU_WB: begin
        advance = 1'b1;
        case (cls)
          CLS_REG_ALU:   reg_write_en = 1'b1;
          CLS_INC_QCLK:  qclk_load_en = 1'b1;
          CLS_JUMP_COND: load = alu_out[0];
          default: ;
        endcase
      end
      default: done = 1'b1;
    endcase
    if (advance) state_nxt = FETCH;
  end

  assign cstrobe = strobe_en & (qclk_val == pulse_time);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      instr_ptr <= '0;
      alu_out   <= '0;
    end else begin
      state   <= state_nxt;
      alu_out <= alu_nxt;
      if (advance)
        instr_ptr <= load ? jump_addr : instr_ptr + {{(CMD_ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_proc_exec_core.sv
// Bench for proc_exec_core: directed programs plus randomized programs,
// all checked every cycle against an instruction-level reference model.
module tb_proc_exec_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  opcode;
  logic [31:0] imm_data, reg_data0, reg_data1, qclk_val, pulse_time;
  logic [7:0]  jump_addr;
  logic        sync_enable, fproc_enable;
  logic [7:0]  instr_ptr;
  logic [31:0] alu_out;
  logic        reg_write_en, qclk_load_en, cstrobe, sync_out_ready, fproc_out_ready, done;

  proc_exec_core #(.DATA_WIDTH(32), .CMD_ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .imm_data(imm_data),
    .reg_data0(reg_data0), .reg_data1(reg_data1), .qclk_val(qclk_val),
    .pulse_time(pulse_time), .jump_addr(jump_addr), .sync_enable(sync_enable),
    .fproc_enable(fproc_enable), .instr_ptr(instr_ptr), .alu_out(alu_out),
    .reg_write_en(reg_write_en), .qclk_load_en(qclk_load_en), .cstrobe(cstrobe),
    .sync_out_ready(sync_out_ready), .fproc_out_ready(fproc_out_ready), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_op   [256];
  logic [31:0] m_imm  [256];
  logic [31:0] m_r0   [256];
  logic [31:0] m_r1   [256];
  logic [31:0] m_pt   [256];
  logic [7:0]  m_jump [256];

  logic [7:0] ptr_last = 8'd0;
  int  cyc = 0;
  int  q_cnt = 0;
  int  q_force = -1;
  bit  rand_mode = 0;
  bit  bench_on = 0;

  // reference model: pointer, cycles spent on the current instruction, halt flag, ALU register
  logic [7:0]  m_pc = 8'd0;
  int          m_k = 0;
  bit          m_halt = 0;
  logic [31:0] m_alu = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] imm,
                                          input logic [31:0] r0, input logic [31:0] r1,
                                          input logic [31:0] q);
    logic [31:0] a, b;
    a = op[3] ? r0 : imm;
    b = (op[7:4] == 4'h4) ? q : r1;
    case (op[2:0])
      3'd0: return a;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return (a == b) ? 32'd1 : 32'd0;
      3'd4: return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return 32'd0;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 3));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      2: return $urandom;
      default: return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
  endfunction

  // compare process
  always @(negedge clk) begin : cmp
    logic [3:0] cls;
    bit e_rwe, e_qle, e_cs, e_sr, e_fr, adv, ld;
    if (bench_on) begin
      cls = opcode[7:4];
      e_rwe = 0; e_qle = 0; e_cs = 0; e_sr = 0; e_fr = 0;
      if (!m_halt && m_k >= 1) begin
        case (cls)
          4'h0: e_rwe = (m_k == 2);
          4'h4: e_qle = (m_k == 2);
          4'h5: e_cs  = (qclk_val == pulse_time);
          4'h7: e_sr  = 1;
          4'h8: e_fr  = 1;
          default: ;
        endcase
      end
      chk("instr_ptr", 32'(instr_ptr), 32'(m_pc));
      chk("alu_out", alu_out, m_alu);
      chk("reg_write_en", 32'(reg_write_en), 32'(e_rwe));
      chk("qclk_load_en", 32'(qclk_load_en), 32'(e_qle));
      chk("cstrobe", 32'(cstrobe), 32'(e_cs));
      chk("sync_out_ready", 32'(sync_out_ready), 32'(e_sr));
      chk("fproc_out_ready", 32'(fproc_out_ready), 32'(e_fr));
      chk("done", 32'(done), 32'(m_halt));
      if (!reset) begin
        m_pc = 8'd0; m_k = 0; m_halt = 0; m_alu = 32'd0;
      end else begin
        adv = 0; ld = 0;
        if (m_halt) begin
        end else if (m_k == 0) begin
          m_k = 1;
        end else begin
          case (cls)
            4'h1: begin adv = 1; ld = 1; end
            4'h0, 4'h4: if (m_k == 1) m_k = 2; else adv = 1;
            4'h2: if (m_k == 1) m_k = 2; else begin adv = 1; ld = m_alu[0]; end
            4'h5: adv = e_cs;
            4'h7: adv = sync_enable;
            4'h8: adv = fproc_enable;
            4'h9: m_halt = 1;
            default: adv = 1;
          endcase
        end
        if (adv) begin
          m_pc = ld ? jump_addr : m_pc + 8'd1;
          m_k = 0;
        end
        m_alu = alu_ref(opcode, imm_data, reg_data0, reg_data1, qclk_val);
      end
    end
  end

  // one clock: inputs follow a one-cycle-latency command memory
  task automatic cycle();
    logic [7:0] a;
    @(posedge clk);
    #1;
    a = ptr_last;
    ptr_last = instr_ptr;
    opcode = m_op[a];
    imm_data = m_imm[a];
    jump_addr = m_jump[a];
    pulse_time = m_pt[a];
    if (rand_mode) begin
      reg_data0 = rnd_opnd();
      reg_data1 = rnd_opnd();
      sync_enable = ($urandom_range(0, 3) == 0);
      fproc_enable = ($urandom_range(0, 3) == 0);
      qclk_val = 32'(q_cnt % 64);
    end else begin
      reg_data0 = m_r0[a];
      reg_data1 = m_r1[a];
      qclk_val = (q_force >= 0) ? 32'(q_force) : 32'(q_cnt);
    end
    q_cnt++;
    cyc++;
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) cycle();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      m_op[i] = 8'h30; m_imm[i] = 0; m_r0[i] = 0; m_r1[i] = 0; m_pt[i] = 0; m_jump[i] = 0;
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic release_reset();
    cycle();
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    reset = 1'b0;
    opcode = 8'h30; imm_data = 0; reg_data0 = 0; reg_data1 = 0; qclk_val = 0;
    pulse_time = 0; jump_addr = 0; sync_enable = 0; fproc_enable = 0;
    clear_mem();
    cycle();
    bench_on = 1;
    cycle();

    // all-NOP program: pointer steps every 2 cycles and wraps
    release_reset();
    chk("nop_ptr_c0", 32'(instr_ptr), 32'd0);
    run_to(3);   chk("nop_ptr_c3", 32'(instr_ptr), 32'd1);
    run_to(510); chk("nop_ptr_c510", 32'(instr_ptr), 32'd255);
    run_to(512); chk("nop_ptr_wrap", 32'(instr_ptr), 32'd0);

    // directed program
    hold_reset();
    clear_mem();
    m_op[8'h00] = 8'h2B; m_r0[8'h00] = 3; m_r1[8'h00] = 3; m_jump[8'h00] = 8'h10;
    m_op[8'h10] = 8'h2B; m_r0[8'h10] = 3; m_r1[8'h10] = 4; m_jump[8'h10] = 8'h80;
    m_op[8'h11] = 8'h02; m_imm[8'h11] = 0; m_r1[8'h11] = 1;
    m_op[8'h12] = 8'h41; m_imm[8'h12] = 4;
    m_op[8'h13] = 8'h50; m_pt[8'h13] = 10;
    m_op[8'h14] = 8'h70;
    m_op[8'h15] = 8'h80;
    m_op[8'h16] = 8'h90;
    q_force = 20;
    release_reset();
    run_to(2);  chk("jc_eq_alu", alu_out, 32'd1);
    run_to(3);  chk("jc_taken_ptr", 32'(instr_ptr), 32'h10);
    run_to(6);  chk("jc_not_taken_ptr", 32'(instr_ptr), 32'h11);
    run_to(7);  chk("sub_rwe_decode", 32'(reg_write_en), 32'd0);
    run_to(8);  chk("sub_alu", alu_out, 32'hFFFF_FFFF);
                chk("sub_rwe", 32'(reg_write_en), 32'd1);
    run_to(9);  chk("sub_rwe_off", 32'(reg_write_en), 32'd0);
    run_to(11); chk("incq_alu", alu_out, 32'd24);
                chk("incq_load", 32'(qclk_load_en), 32'd1);
    run_to(12);
    q_force = -1; q_cnt = 0;
    run_to(22); chk("pulse_early", 32'(cstrobe), 32'd0);
    run_to(23); chk("pulse_hit", 32'(cstrobe), 32'd1);
    run_to(24); chk("pulse_adv", 32'(instr_ptr), 32'h14);
    run_to(29); chk("sync_wait_rdy", 32'(sync_out_ready), 32'd1);
                chk("sync_wait_ptr", 32'(instr_ptr), 32'h14);
    sync_enable = 1;
    run_to(30);
    sync_enable = 0;
    run_to(31); chk("sync_adv", 32'(instr_ptr), 32'h15);
    run_to(36); chk("fproc_wait_rdy", 32'(fproc_out_ready), 32'd1);
    fproc_enable = 1;
    run_to(37);
    fproc_enable = 0;
    run_to(38); chk("fproc_adv", 32'(instr_ptr), 32'h16);
    run_to(40); chk("halt_done", 32'(done), 32'd1);
    run_to(45); chk("halt_ptr", 32'(instr_ptr), 32'h16);
    reset = 1'b0;
    run_to(47); chk("halt_rst_done", 32'(done), 32'd0);
                chk("halt_rst_ptr", 32'(instr_ptr), 32'd0);

    // reset in the middle of a sync wait
    m_op[8'h00] = 8'h70;
    release_reset();
    run_to(4);  chk("msync_rdy", 32'(sync_out_ready), 32'd1);
    reset = 1'b0;
    run_to(6);  chk("msync_rst_rdy", 32'(sync_out_ready), 32'd0);
                chk("msync_rst_ptr", 32'(instr_ptr), 32'd0);
                chk("msync_rst_alu", alu_out, 32'd0);

    // randomized programs
    rand_mode = 1;
    for (int r = 0; r < 8; r++) begin
      hold_reset();
      for (int i = 0; i < 256; i++) begin
        logic [3:0] c;
        case ($urandom_range(0, 11))
          0, 1: c = 4'h0;
          2:    c = 4'h1;
          3, 4: c = 4'h2;
          5:    c = 4'h4;
          6:    c = 4'h5;
          7:    c = 4'h7;
          8:    c = 4'h8;
          9:    c = 4'(3 + 3 * $urandom_range(0, 1));
          10:   c = 4'(10 + $urandom_range(0, 5));
          default: c = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'h0;
        endcase
        m_op[i] = {c, 4'($urandom_range(0, 15))};
        m_imm[i] = rnd_opnd();
        m_pt[i] = 32'($urandom_range(0, 63));
        m_jump[i] = 8'($urandom_range(0, 255));
      end
      release_reset();
      for (int i = 0; i < 700; i++) begin
        reset = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
        cycle();
      end
    end

    bench_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
